// File: rtl/plot_stream_sink_pkg.sv
// Shared constants for the pixel-plot path: screen geometry, pixel format and
// the shift-add form of the linear frame-buffer address (y*160 + x).
package plot_stream_sink_pkg;

  localparam int H_RES            = 160;
  localparam int V_RES            = 120;
  localparam int PIXELS_PER_FRAME = H_RES * V_RES;
  localparam int COLOUR_W         = 3;
  localparam int ADDR_W           = 15;
  localparam int FIFO_DEPTH       = 4;

  // y*160 = (y<<7) + (y<<5); the sweep generators use the same pair
  localparam int ADDR_Y_SHIFT_HI = 7;
  localparam int ADDR_Y_SHIFT_LO = 5;

  // Linear address of (x, y), returned 32 bits wide so callers can size it
  function automatic logic [31:0] xy_to_addr(input logic [7:0] x, input logic [6:0] y);
    logic [31:0] y_ext;
    logic [31:0] x_ext;
    y_ext = {25'd0, y};
    x_ext = {24'd0, x};
    return (y_ext << ADDR_Y_SHIFT_HI) + (y_ext << ADDR_Y_SHIFT_LO) + x_ext;
  endfunction

endpackage

// File: rtl/plot_stream_sink_fifo.sv
// Small synchronous FIFO with occupancy count. DEPTH must be a power of two
// so the read/write pointers wrap on their own. Head entry is read
// combinationally; push and pop on the same edge leave occupancy unchanged.
module small_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;

  // Storage array; contents are don't-care while the entry is not occupied
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/plot_stream_sink.sv
// Receiving end of the pixel-plot interface: range-checks each pixel, turns
// it into a frame-buffer address, buffers it and issues one write per cycle
// to the frame-buffer port while it is not stalled. Counts writes per frame
// and pulses frame_done on the last write of a full frame.
//
// Handshake: a pixel (x_in, y_in, colour_in) is transferred on a rising CLK
// edge where plot=1 and ready=1. ready depends only on FIFO occupancy, never
// on plot, so the generator must hold its pixel stable until that edge.
// Out-of-range pixels still complete the handshake but are only counted.
module plot_stream_sink
  import plot_stream_sink_pkg::*;
#(
  parameter int H_RES      = plot_stream_sink_pkg::H_RES,
  parameter int V_RES      = plot_stream_sink_pkg::V_RES,
  parameter int COLOUR_W   = plot_stream_sink_pkg::COLOUR_W,
  parameter int FIFO_DEPTH = plot_stream_sink_pkg::FIFO_DEPTH,
  parameter int ADDR_W     = plot_stream_sink_pkg::ADDR_W
) (
  input  logic                CLK,
  input  logic                resetn,
  input  logic                plot,
  input  logic [7:0]          x_in,
  input  logic [6:0]          y_in,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic                ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_we,
  input  logic                mem_busy,
  output logic                frame_done,
  output logic [ADDR_W-1:0]   pixel_count,
  output logic [7:0]          drop_count
);

  localparam int ENTRY_W      = ADDR_W + COLOUR_W;
  localparam int FRAME_PIXELS = H_RES * V_RES;

  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        fifo_count_unused;
  logic [ENTRY_W-1:0]          fifo_din;
  logic [ENTRY_W-1:0]          fifo_dout;
  logic                        accept;
  logic                        in_range;
  logic                        push;
  logic                        pop;
  logic                        last_of_frame;

  assign ready    = !fifo_full;
  assign accept   = plot && ready;
  assign in_range = (x_in < 8'(H_RES)) && (y_in < 7'(V_RES));
  assign push     = accept && in_range;
  assign pop      = !fifo_empty && !mem_busy;
  assign fifo_din = {ADDR_W'(xy_to_addr(x_in, y_in)), colour_in};

  // Occupancy is only needed inside the FIFO for full/empty
  assign fifo_count_unused = ^fifo_count;

  assign last_of_frame = (pixel_count == ADDR_W'(FRAME_PIXELS - 1));

  small_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK    (CLK),
    .resetn (resetn),
    .push   (push),
    .din    (fifo_din),
    .pop    (pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Issue stage: pop the head into the registered write port and count frames
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      frame_done  <= 1'b0;
      pixel_count <= '0;
    end else begin
      mem_we     <= pop;
      frame_done <= 1'b0;
      if (pop) begin
        mem_addr <= fifo_dout[ENTRY_W-1:COLOUR_W];
        mem_data <= fifo_dout[COLOUR_W-1:0];
        if (last_of_frame) begin
          pixel_count <= '0;
          frame_done  <= 1'b1;
        end else begin
          pixel_count <= pixel_count + 1'b1;
        end
      end
    end
  end

  // Saturating count of accepted pixels that fell outside the screen
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      drop_count <= '0;
    end else if (accept && !in_range && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_plot_stream_sink.sv
// Bench for plot_stream_sink: directed table of single pixels with hand-computed
// addresses, then multi-cycle sequences for drop saturation, back-pressure,
// mid-operation reset and a full raster frame.
module tb_plot_stream_sink;

  localparam int ADDR_W   = 15;
  localparam int COLOUR_W = 3;
  localparam int W        = ADDR_W + COLOUR_W;
  localparam int FRAME    = 19200;

  logic                CLK;
  logic                resetn;
  logic                plot;
  logic [7:0]          x_in;
  logic [6:0]          y_in;
  logic [COLOUR_W-1:0] colour_in;
  logic                ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic [COLOUR_W-1:0] mem_data;
  logic                mem_we;
  logic                mem_busy;
  logic                frame_done;
  logic [ADDR_W-1:0]   pixel_count;
  logic [7:0]          drop_count;

  plot_stream_sink dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .plot        (plot),
    .x_in        (x_in),
    .y_in        (y_in),
    .colour_in   (colour_in),
    .ready       (ready),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_we      (mem_we),
    .mem_busy    (mem_busy),
    .frame_done  (frame_done),
    .pixel_count (pixel_count),
    .drop_count  (drop_count)
  );

  // ---------------- clock / watchdog ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int  model_wr  = 0;
  int  exp_drop  = 0;
  int  fd_count  = 0;
  int  fd_addr   = -1;
  int  run_len   = 0;
  int  max_run   = 0;
  bit  mon_en    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_entry(input int x, input int y, input int c);
    int addr;
    addr = y * 160 + x;
    return {ADDR_W'(addr), COLOUR_W'(c)};
  endfunction

  // Write-port monitor: every write must match the queue head, in order
  always @(negedge CLK) begin
    if (mon_en) begin
      if (mem_we === 1'b1) begin
        logic [W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: got write addr=%0d data=%0d, expected no write at %0t",
                   mem_addr, mem_data, $time);
        end else begin
          e = exp_q.pop_front();
          model_wr++;
          chk("wr_addr", 32'(mem_addr), 32'(e[W-1:COLOUR_W]));
          chk("wr_data", 32'(mem_data), 32'(e[COLOUR_W-1:0]));
          chk("wr_pixel_count", 32'(pixel_count), 32'(model_wr % FRAME));
          chk("wr_frame_done", 32'(frame_done), 32'((model_wr % FRAME) == 0));
        end
        if (frame_done === 1'b1) begin
          fd_count++;
          fd_addr = int'(mem_addr);
        end
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        chk("idle_we", 32'(mem_we), 32'd0);
        chk("idle_frame_done", 32'(frame_done), 32'd0);
        run_len = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one pixel; returns after the accepting edge (plus 1 time unit)
  task automatic send_pixel(input int x, input int y, input int c, output bit ok);
    int waited;
    waited    = 0;
    plot      = 1'b1;
    x_in      = 8'(x);
    y_in      = 7'(y);
    colour_in = COLOUR_W'(c);
    while (ready !== 1'b1 && waited < 200) begin
      @(posedge CLK);
      #1;
      waited++;
    end
    if (ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: ready stayed %b for %0d cycles, expected 1", ready, waited);
      ok = 1'b0;
    end else begin
      @(posedge CLK);
      #1;
      ok = 1'b1;
    end
    plot = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && mem_we === 1'b0) break;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int x;
    int y;
    int c;
    bit valid;
    int exp_addr;
    int exp_data;
    int exp_pc;
    int exp_drop;
  } vec_t;

  vec_t tbl[10];

  initial begin
    bit ok;

    tbl[0] = '{5,   2,   5, 1'b1, 325,   5, 1, 0};
    tbl[1] = '{159, 119, 7, 1'b1, 19199, 7, 2, 0};
    tbl[2] = '{0,   0,   2, 1'b1, 0,     2, 3, 0};
    tbl[3] = '{10,  1,   1, 1'b1, 170,   1, 4, 0};
    tbl[4] = '{100, 50,  6, 1'b1, 8100,  6, 5, 0};
    tbl[5] = '{160, 10,  3, 1'b0, 0,     0, 5, 1};
    tbl[6] = '{3,   120, 4, 1'b0, 0,     0, 5, 2};
    tbl[7] = '{255, 127, 1, 1'b0, 0,     0, 5, 3};
    tbl[8] = '{159, 0,   3, 1'b1, 159,   3, 6, 3};
    tbl[9] = '{0,   119, 6, 1'b1, 19040, 6, 7, 3};

    // reset block
    resetn    = 1'b0;
    plot      = 1'b0;
    x_in      = '0;
    y_in      = '0;
    colour_in = '0;
    mem_busy  = 1'b0;
    repeat (3) @(posedge CLK);
    #1 resetn = 1'b1;
    @(negedge CLK);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_pixel_count", 32'(pixel_count), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    mon_en = 1'b1;

    // table: single pixels, latency of 2 edges, one-cycle strobe
    for (int i = 0; i < 10; i++) begin
      send_pixel(tbl[i].x, tbl[i].y, tbl[i].c, ok);
      if (ok && tbl[i].valid)
        exp_q.push_back({ADDR_W'(tbl[i].exp_addr), COLOUR_W'(tbl[i].exp_data)});
      @(negedge CLK);
      chk("tbl_we_early", 32'(mem_we), 32'd0);
      @(negedge CLK);
      chk("tbl_we", 32'(mem_we), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk("tbl_addr", 32'(mem_addr), 32'(tbl[i].exp_addr));
        chk("tbl_data", 32'(mem_data), 32'(tbl[i].exp_data));
      end
      chk("tbl_pixel_count", 32'(pixel_count), 32'(tbl[i].exp_pc));
      @(negedge CLK);
      chk("tbl_we_late", 32'(mem_we), 32'd0);
      chk("tbl_ready", 32'(ready), 32'd1);
      chk("tbl_drop_count", 32'(drop_count), 32'(tbl[i].exp_drop));
    end
    exp_drop = 3;

    // drop saturation: 300 out-of-range pixels back-to-back
    for (int i = 0; i < 300; i++) begin
      send_pixel(160 + (i % 96), $urandom_range(0, 127), i % 8, ok);
      if (ok) exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
      if (i == 250 || i == 251 || i == 299)
        chk("drop_sat", 32'(drop_count), 32'(exp_drop));
    end
    wait_drain();

    // back-pressure: 4 accepted while stalled, 5th held, then release
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_pixel(10 + i, 3, i, ok);
      if (ok) exp_q.push_back(model_entry(10 + i, 3, i));
    end
    plot      = 1'b1;
    x_in      = 8'd14;
    y_in      = 7'd3;
    colour_in = 3'd4;
    chk("bp_ready_full", 32'(ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      chk("bp_ready_held", 32'(ready), 32'd0);
    end
    mem_busy = 1'b0;
    max_run  = 0;
    @(posedge CLK);
    #1;
    chk("bp_ready_freed", 32'(ready), 32'd1);
    @(posedge CLK);
    exp_q.push_back(model_entry(14, 3, 4));
    #1;
    x_in      = 8'd15;
    colour_in = 3'd5;
    chk("bp_ready_6th", 32'(ready), 32'd1);
    @(posedge CLK);
    exp_q.push_back(model_entry(15, 3, 5));
    #1;
    plot = 1'b0;
    wait_drain();
    chk("bp_consecutive_writes", 32'(max_run), 32'd6);

    // reset with pixels queued behind a stall
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) send_pixel(20 + i, 5, i, ok);
    resetn = 1'b0;
    @(posedge CLK);
    #1;
    resetn   = 1'b1;
    mem_busy = 1'b0;
    model_wr = 0;
    exp_drop = 0;
    fd_count = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("rstmid_we", 32'(mem_we), 32'd0);
      chk("rstmid_ready", 32'(ready), 32'd1);
    end
    chk("rstmid_pixel_count", 32'(pixel_count), 32'd0);
    chk("rstmid_drop_count", 32'(drop_count), 32'd0);

    // full raster frame
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        send_pixel(x, y, (x + y) % 8, ok);
        if (ok) exp_q.push_back(model_entry(x, y, (x + y) % 8));
      end
    end
    wait_drain();
    @(negedge CLK);
    chk("frame_pixel_count_wrapped", 32'(pixel_count), 32'd0);
    chk("frame_done_pulses", 32'(fd_count), 32'd1);
    chk("frame_done_addr", 32'(fd_addr), 32'd19199);
    chk("frame_writes", 32'(model_wr), 32'(FRAME));

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
